// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: op codes, FSM states
// and byte-enable patterns.
package mem_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LB  = 3'd1,
    LBU = 3'd2,
    LH  = 3'd3,
    LHU = 3'd4,
    SW  = 3'd5,
    SB  = 3'd6,
    SH  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Selects the addressed byte/halfword of a memory word and zero- or
// sign-extends it to 32 bits; stores yield 0.
module load_extender
  import mem_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (op)
      LW:      value = word;
      LB:      value = {{24{byte_sel[7]}}, byte_sel};
      LBU:     value = {24'd0, byte_sel};
      LH:      value = {{16{half_sel[15]}}, half_sel};
      LHU:     value = {16'd0, half_sel};
      default: value = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access unit: one request at a time, word-aligned memory
// handshake with timeout, lane-replicated stores and extended loads.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state, state_nxt;
  op_e         op_in, op_r;
  logic [1:0]  lane_r;
  logic [7:0]  cnt;
  logic        accept, bad_align, timed_out;
  logic [31:0] ext_data;

  function automatic logic is_misaligned(op_e o, logic [1:0] a);
    case (o)
      LH, LHU, SH: return a[0];
      LW, SW:      return a != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(op_e o);
    return o inside {SW, SB, SH};
  endfunction

  function automatic logic [3:0] store_be(op_e o, logic [1:0] a);
    case (o)
      SB:      return BE_BYTE << a;
      SH:      return BE_HALF << a;
      default: return BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] store_data(op_e o, logic [31:0] d);
    case (o)
      SB:      return {4{d[7:0]}};
      SH:      return {2{d[15:0]}};
      SW:      return d;
      default: return 32'd0;
    endcase
  endfunction

  assign op_in     = op_e'(op);
  assign accept    = req_valid & req_ready;
  assign bad_align = is_misaligned(op_in, addr[1:0]);
  assign timed_out = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad_align ? RESP : ACCESS;
      ACCESS:  if (mem_ack || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    mem_req   = (state == ACCESS);
  end

  load_extender u_load_extender (
    .op    (op_r),
    .lane  (lane_r),
    .word  (mem_rdata),
    .value (ext_data)
  );

  // Request capture and timeout counter; memory-side fields stay put until the next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r      <= LW;
      lane_r    <= 2'd0;
      cnt       <= 8'd0;
      mem_we    <= 1'b0;
      mem_be    <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else if (accept) begin
      op_r   <= op_in;
      lane_r <= addr[1:0];
      cnt    <= 8'd0;
      if (!bad_align) begin
        mem_we    <= is_store(op_in);
        mem_be    <= store_be(op_in, addr[1:0]);
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wdata <= store_data(op_in, wdata);
      end
    end else if (state == ACCESS && !mem_ack) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Response registers: loaded on entry to RESP, cleared in every other cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      rdata      <= 32'd0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      rdata      <= 32'd0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      if (accept && bad_align) begin
        resp_valid <= 1'b1;
        misaligned <= 1'b1;
      end else if (state == ACCESS) begin
        if (mem_ack) begin
          resp_valid <= 1'b1;
          rdata      <= is_store(op_r) ? 32'd0 : ext_data;
        end else if (timed_out) begin
          resp_valid <= 1'b1;
          bus_err    <= 1'b1;
        end
      end
    end
  end

endmodule
